iir_filter_sequencer: RTL and testbench

//  Sequences and configures one shared multi-cycle IIR filter core (start_i/done_o, coefficient-array inputs).

---
 rtl/iir_seq_pkg.sv | 29 ++
 rtl/iir_coeff_bank.sv | 58 +++++
 rtl/iir_filter_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_iir_filter_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_seq_pkg.sv
// Shared types and defaults for the IIR filter sequencer.
//   state_e   : sequencer FSM states
//   cfg_sel_e : coefficient bank selector (numerator / denominator)
//   DEF_*     : default parameter values
//   addr_width: tap-index width, never narrower than one bit
package iir_seq_pkg;

  localparam int unsigned DEF_NUM_COEFFS     = 32'd5;
  localparam int unsigned DEF_BITWIDTH       = 32'd24;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } state_e;

  typedef enum logic {
    CFG_NUM = 1'b0,
    CFG_DEN = 1'b1
  } cfg_sel_e;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// One coefficient bank: a shadow register array written tap by tap and an
// active array that the filter core sees.
//   clk_i, reset_i : clock, synchronous active-low reset
//   we_i           : write data_i into shadow tap addr_i (out-of-range ignored)
//   addr_i, data_i : tap index and signed coefficient
//   apply_i        : copy shadow to active (a write in the same cycle is included)
//   active_o       : active coefficients, only change on apply_i
module iir_coeff_bank
  import iir_seq_pkg::*;
#(
  parameter int unsigned NUM_COEFFS = DEF_NUM_COEFFS,
  parameter int unsigned BITWIDTH   = DEF_BITWIDTH,
  parameter int unsigned ADDR_W     = addr_width(DEF_NUM_COEFFS)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 we_i,
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [BITWIDTH-1:0]                  data_i,
  input  logic                                 apply_i,
  output logic [NUM_COEFFS-1:0][BITWIDTH-1:0]  active_o
);

  logic [NUM_COEFFS-1:0][BITWIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_COEFFS-1:0][BITWIDTH-1:0] active_q, active_d;

  // Shadow write decode and apply; the forwarded shadow_d lets a write in the
  // apply cycle land in the active bank too.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < int'(NUM_COEFFS); i++) begin
      if (we_i && (addr_i == ADDR_W'(i))) begin
        shadow_d[i] = data_i;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
    if (apply_i) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/iir_filter_sequencer.sv
// Sequencer for one shared multi-cycle IIR filter core.
//   sample_*  : valid/ready input of signed samples
//   result_*  : valid/ready output of core results
//   cfg_*     : shadow coefficient writes and commit request; cfg_pending_o
//               stays high until the commit has been applied between samples
//   core_*    : start pulse, held input sample, done and result from the core
//   num/den_coeffs_o : active coefficient banks, constant while the core runs
//   busy_o    : FSM not idle; error_o: sticky timeout, cleared by error_clear_i
// All outputs are registered.
module iir_filter_sequencer
  import iir_seq_pkg::*;
#(
  parameter  int unsigned NUM_COEFFS     = DEF_NUM_COEFFS,
  parameter  int unsigned BITWIDTH       = DEF_BITWIDTH,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned ADDR_W         = addr_width(NUM_COEFFS)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 sample_valid_i,
  output logic                                 sample_ready_o,
  input  logic [BITWIDTH-1:0]                  sample_i,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic [BITWIDTH-1:0]                  result_o,
  input  logic                                 cfg_we_i,
  input  logic                                 cfg_sel_i,
  input  logic [ADDR_W-1:0]                    cfg_addr_i,
  input  logic [BITWIDTH-1:0]                  cfg_data_i,
  input  logic                                 cfg_commit_i,
  output logic                                 cfg_pending_o,
  output logic                                 core_start_o,
  output logic [BITWIDTH-1:0]                  core_signal_o,
  input  logic                                 core_done_i,
  input  logic [BITWIDTH-1:0]                  core_signal_i,
  output logic [NUM_COEFFS-1:0][BITWIDTH-1:0]  num_coeffs_o,
  output logic [NUM_COEFFS-1:0][BITWIDTH-1:0]  den_coeffs_o,
  output logic                                 busy_o,
  output logic                                 error_o,
  input  logic                                 error_clear_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 32'd1);

  state_e              state_q, state_d;
  logic                capt_q, capt_d;      // sample captured on the way into APPLY
  logic [BITWIDTH-1:0] sig_q, sig_d;
  logic [BITWIDTH-1:0] res_q, res_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;
  logic                ready_q, start_q, busy_q, valid_q;
  logic                apply_s, timeout_s, hs_s;
  logic                we_num_s, we_den_s;

  assign hs_s = sample_valid_i && ready_q;

  // Next-state logic for the sequencer FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    capt_d    = capt_q;
    sig_d     = sig_q;
    res_d     = res_q;
    timer_d   = timer_q;
    apply_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = APPLY;
        end else if (hs_s) begin
          sig_d = sample_i;
          // A commit arriving with the sample is applied before the start.
          if (cfg_commit_i) begin
            state_d = APPLY;
            capt_d  = 1'b1;
          end else begin
            state_d = START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        apply_s = 1'b1;
        capt_d  = 1'b0;
        if (capt_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (core_done_i) begin
          res_d   = core_signal_i;
          state_d = OUTPUT;
        end else if (timer_d == TW'(TIMEOUT_CYCLES)) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      OUTPUT: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = IDLE;
        capt_d  = 1'b0;
      end
    endcase

    // Writes up to and including the APPLY cycle are folded in, so a commit
    // seen during APPLY is already satisfied.
    pend_d = apply_s ? 1'b0 : (pend_q | cfg_commit_i);
    // Timeout wins over a simultaneous clear.
    err_d  = timeout_s ? 1'b1 : (error_clear_i ? 1'b0 : err_q);
  end

  // FSM, datapath and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      capt_q  <= 1'b0;
      sig_q   <= '0;
      res_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      capt_q  <= capt_d;
      sig_q   <= sig_d;
      res_q   <= res_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      ready_q <= (state_d == IDLE) && !pend_d;
      start_q <= (state_d == START);
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == OUTPUT);
    end
  end

  assign we_num_s = cfg_we_i && (cfg_sel_e'(cfg_sel_i) == CFG_NUM);
  assign we_den_s = cfg_we_i && (cfg_sel_e'(cfg_sel_i) == CFG_DEN);

  iir_coeff_bank #(
    .NUM_COEFFS (NUM_COEFFS),
    .BITWIDTH   (BITWIDTH),
    .ADDR_W     (ADDR_W)
  ) u_num_bank (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .we_i     (we_num_s),
    .addr_i   (cfg_addr_i),
    .data_i   (cfg_data_i),
    .apply_i  (apply_s),
    .active_o (num_coeffs_o)
  );

  iir_coeff_bank #(
    .NUM_COEFFS (NUM_COEFFS),
    .BITWIDTH   (BITWIDTH),
    .ADDR_W     (ADDR_W)
  ) u_den_bank (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .we_i     (we_den_s),
    .addr_i   (cfg_addr_i),
    .data_i   (cfg_data_i),
    .apply_i  (apply_s),
    .active_o (den_coeffs_o)
  );

  assign sample_ready_o = ready_q;
  assign result_valid_o = valid_q;
  assign result_o       = res_q;
  assign cfg_pending_o  = pend_q;
  assign core_start_o   = start_q;
  assign core_signal_o  = sig_q;
  assign busy_o         = busy_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_iir_filter_sequencer.sv
// Self-checking bench for iir_filter_sequencer with a core stub of
// programmable latency that returns sample + 1.
module tb_iir_filter_sequencer;

  localparam int NC = 5;
  localparam int BW = 24;
  localparam int TO = 64;
  localparam int AW = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                        reset_i;
  logic                        sample_valid_i, sample_ready_o;
  logic [BW-1:0]               sample_i;
  logic                        result_valid_o, result_ready_i;
  logic [BW-1:0]               result_o;
  logic                        cfg_we_i, cfg_sel_i, cfg_commit_i, cfg_pending_o;
  logic [AW-1:0]               cfg_addr_i;
  logic [BW-1:0]               cfg_data_i;
  logic                        core_start_o;
  logic [BW-1:0]               core_signal_o;
  logic                        core_done_i = 1'b0;
  logic [BW-1:0]               core_signal_i = '0;
  logic [NC-1:0][BW-1:0]       num_coeffs_o, den_coeffs_o;
  logic                        busy_o, error_o, error_clear_i;

  iir_filter_sequencer #(.NUM_COEFFS(NC), .BITWIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o), .sample_i(sample_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_o(result_o),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_commit_i(cfg_commit_i), .cfg_pending_o(cfg_pending_o),
    .core_start_o(core_start_o), .core_signal_o(core_signal_o),
    .core_done_i(core_done_i), .core_signal_i(core_signal_i),
    .num_coeffs_o(num_coeffs_o), .den_coeffs_o(den_coeffs_o),
    .busy_o(busy_o), .error_o(error_o), .error_clear_i(error_clear_i)
  );

  // Core stub: done pulse some cycles after start (0 = never), returns input + 1.
  int            stub_lat = 0;
  int            stub_cnt = 0;
  logic [BW-1:0] stub_val = '0;
  int            start_cnt = 0;
  always @(posedge clk_i) begin
    core_done_i <= 1'b0;
    if (!reset_i) begin
      stub_cnt <= 0;
    end else if (core_start_o) begin
      stub_cnt  <= stub_lat;
      stub_val  <= core_signal_o + 24'd1;
      start_cnt <= start_cnt + 1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        core_done_i   <= 1'b1;
        core_signal_i <= stub_val;
      end
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: shadow contents, what the active banks must hold, and
  // whether a commit is outstanding.
  int m_shadow  [2][NC];
  int m_applied [2][NC];
  bit m_commit;

  typedef struct { int sel; int addr; int data; } cfg_vec_t;
  typedef struct { int x; int lat; int exp; int hold; } smp_vec_t;

  function automatic longint sx(input logic [BW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic int wrap24(input int v);
    if (v > 8388607) return v - 16777216;
    else if (v < -8388608) return v + 16777216;
    else return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply_model();
    if (m_commit) begin
      m_applied = m_shadow;
      m_commit  = 1'b0;
    end
  endtask

  task automatic check_banks(input string nm);
    for (int i = 0; i < NC; i++) begin
      chk({nm, " num"}, sx(num_coeffs_o[i]), m_applied[0][i]);
      chk({nm, " den"}, sx(den_coeffs_o[i]), m_applied[1][i]);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " sample_ready"}, sample_ready_o, 0);
    chk({nm, " result_valid"}, result_valid_o, 0);
    chk({nm, " result"}, result_o, 0);
    chk({nm, " pending"}, cfg_pending_o, 0);
    chk({nm, " core_start"}, core_start_o, 0);
    chk({nm, " core_signal"}, core_signal_o, 0);
    chk({nm, " busy"}, busy_o, 0);
    chk({nm, " error"}, error_o, 0);
    chk({nm, " num nonzero"}, (num_coeffs_o != '0), 0);
    chk({nm, " den nonzero"}, (den_coeffs_o != '0), 0);
  endtask

  task automatic cfg_write(input int sel, input int addr, input int data);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel[0];
    cfg_addr_i = addr[AW-1:0];
    cfg_data_i = data[BW-1:0];
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    if (addr < NC) m_shadow[sel][addr] = data;
  endtask

  task automatic cfg_commit();
    cfg_commit_i = 1'b1;
    @(negedge clk_i);
    cfg_commit_i = 1'b0;
    m_commit = 1'b1;
  endtask

  // Offer a sample until accepted; optionally commit in the handshake cycle.
  task automatic send(input int x, input bit cc);
    bit ok = 1'b0;
    sample_valid_i = 1'b1;
    sample_i       = x[BW-1:0];
    for (int i = 0; i < 50; i++) begin
      if (sample_ready_o) begin
        cfg_commit_i = cc;
        ok = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0;
    cfg_commit_i   = 1'b0;
    chk("sample accepted", ok, 1);
    if (cc) m_commit = 1'b1;
    apply_model();
  endtask

  // Expect the start pulse 1 cycle after the handshake, 2 with an APPLY.
  task automatic wait_start(input int x, input bit cc);
    int d = 0;
    for (int i = 1; i <= 4; i++) begin
      if (core_start_o) begin d = i; break; end
      @(negedge clk_i);
    end
    chk("start latency", d, cc ? 2 : 1);
    chk("core_signal_o", sx(core_signal_o), x);
    chk("pending at start", cfg_pending_o, 0);
    check_banks("start");
  endtask

  task automatic run_sample(input int x, input int lat, input int exp, input int hold,
                            input bit cc, input bit mid, input int msel, input int maddr,
                            input int mdata);
    int  s0;
    bit  ok = 1'b0;
    stub_lat = lat;
    s0 = start_cnt;
    send(x, cc);
    wait_start(x, cc);
    if (mid) begin
      cfg_write(msel, maddr, mdata);
      cfg_commit();
      chk("pending mid", cfg_pending_o, 1);
      chk("active held mid", sx(msel[0] ? den_coeffs_o[maddr] : num_coeffs_o[maddr]),
          m_applied[msel][maddr]);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (core_done_i) begin ok = 1'b1; break; end
    end
    chk("done seen", ok, 1);
    chk("valid at done", result_valid_o, 0);
    check_banks("busy");
    @(negedge clk_i);
    chk("valid after done", result_valid_o, 1);
    chk("result", sx(result_o), exp);
    result_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold valid", result_valid_o, 1);
      chk("hold result", sx(result_o), exp);
      chk("hold sample_ready", sample_ready_o, 0);
    end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    chk("valid dropped", result_valid_o, 0);
    chk("pending after result", cfg_pending_o, m_commit);
    chk("start count", start_cnt - s0, 1);
  endtask

  task automatic run_timeout(input int x, input bit hold_clear);
    int k = 0;
    bit v = 1'b0;
    stub_lat      = 0;
    error_clear_i = hold_clear;
    send(x, 1'b0);
    wait_start(x, 1'b0);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk_i);
      v = v | result_valid_o;
      if (error_o) begin k = i; break; end
    end
    chk("timeout cycle", k, TO + 1);
    chk("no result on timeout", v, 0);
    chk("idle after timeout", busy_o, 0);
    if (hold_clear) begin
      @(negedge clk_i);
      chk("clear after timeout", error_o, 0);
    end else begin
      repeat (3) @(negedge clk_i);
      chk("error sticky", error_o, 1);
      error_clear_i = 1'b1;
      @(negedge clk_i);
      chk("error cleared", error_o, 0);
    end
    error_clear_i = 1'b0;
  endtask

  cfg_vec_t cfg_tab [12];
  smp_vec_t smp_tab [5];
  int       exp_num [NC];
  int       exp_den [NC];

  initial begin
    cfg_tab = '{'{0,0,8852}, '{0,1,0}, '{0,2,-17705}, '{0,3,0}, '{0,4,8852},
                '{1,0,1048575}, '{1,1,-3460263}, '{1,2,4674299}, '{1,3,-3009671},
                '{1,4,794344}, '{0,5,999}, '{1,7,-5}};
    exp_num = '{8852, 0, -17705, 0, 8852};
    exp_den = '{1048575, -3460263, 4674299, -3009671, 794344};
    smp_tab = '{'{100,10,101,0}, '{-1,3,0,5}, '{8388607,1,-8388608,0},
                '{-8388608,7,-8388607,2}, '{0,2,1,1}};

    reset_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0; result_ready_i = 1'b0;
    cfg_we_i = 1'b0; cfg_sel_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    cfg_commit_i = 1'b0; error_clear_i = 1'b0; m_commit = 1'b0;
    foreach (m_shadow[s, i]) begin m_shadow[s][i] = 0; m_applied[s][i] = 0; end
    repeat (3) @(negedge clk_i);
    chk_zero("reset");
    reset_i = 1'b1;
    @(negedge clk_i);

    // Coefficient load and commit.
    foreach (cfg_tab[i]) cfg_write(cfg_tab[i].sel, cfg_tab[i].addr, cfg_tab[i].data);
    chk("active untouched by shadow", (num_coeffs_o != '0) || (den_coeffs_o != '0), 0);
    chk("pending before commit", cfg_pending_o, 0);
    cfg_commit();
    chk("pending after commit", cfg_pending_o, 1);
    begin
      int n = 0;
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk_i);
        if (!cfg_pending_o) begin n = i; break; end
      end
      chk("apply cycles", n, 2);
    end
    for (int i = 0; i < NC; i++) begin
      chk("loaded num", sx(num_coeffs_o[i]), exp_num[i]);
      chk("loaded den", sx(den_coeffs_o[i]), exp_den[i]);
    end
    apply_model();

    // Table-driven samples, including back-pressure and wrap boundaries.
    foreach (smp_tab[i])
      run_sample(smp_tab[i].x, smp_tab[i].lat, smp_tab[i].exp, smp_tab[i].hold,
                 1'b0, 1'b0, 0, 0, 0);

    // Commit during WAIT is deferred until after the result, then applied first.
    run_sample(200, 20, 201, 0, 1'b0, 1'b1, 0, 2, 7);
    run_sample(300, 5, 301, 0, 1'b0, 1'b0, 0, 0, 0);
    chk("num[2] applied", sx(num_coeffs_o[2]), 7);

    // Timeouts: sticky flag, then timeout beating a held clear.
    run_timeout(400, 1'b0);
    run_timeout(401, 1'b1);

    // Reset during WAIT aborts the sample.
    stub_lat = 30;
    send(77, 1'b0);
    wait_start(77, 1'b0);
    repeat (5) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk_zero("mid reset");
    reset_i = 1'b1;
    foreach (m_shadow[s, i]) begin m_shadow[s][i] = 0; m_applied[s][i] = 0; end
    m_commit = 1'b0;
    begin
      bit v = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        v = v | result_valid_o;
      end
      chk("no result after reset", v, 0);
    end
    run_sample(55, 3, 56, 0, 1'b0, 1'b0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 30; it++) begin
      logic [BW-1:0] r;
      int  x, lat;
      bit  cc, mid;
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, 1), $urandom_range(0, 7), wrap24($urandom_range(0, 16777215)));
      if ($urandom_range(0, 3) == 0) cfg_commit();
      r   = $urandom();
      x   = int'(sx(r));
      cc  = ($urandom_range(0, 4) == 0);
      mid = ($urandom_range(0, 4) == 0);
      lat = mid ? $urandom_range(8, 12) : $urandom_range(1, 12);
      run_sample(x, lat, wrap24(x + 1), $urandom_range(0, 3), cc, mid,
                 $urandom_range(0, 1), $urandom_range(0, NC - 1),
                 wrap24($urandom_range(0, 16777215)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
